odd_seq_monitor: RTL

Downstream consumer of the 8-bit odd counter stream. It checks each valid sample against the expected odd sequence (previous + 2, modulo 2^WIDTH) and runs a lock/acquire state machine with flywheel tolerance. It keeps saturating error and wrap counters, and exposes lock status for the bench and for later integration stages.

---
 rtl/odd_mon_pkg.sv | 18 +
 rtl/odd_seq_monitor_sat_counter.sv | 35 +++
 rtl/odd_seq_monitor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/odd_mon_pkg.sv
// Shared types and helpers for the odd-sequence monitor: FSM state encoding
// and the expected-next-value function.
package odd_mon_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Callers truncate the result to their sample width, giving modulo 2^WIDTH.
    function automatic logic [31:0] next_odd(input logic [31:0] ref_v);
        return ref_v + 32'd2;
    endfunction

endpackage

// File: rtl/odd_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// rolling over.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/odd_seq_monitor.sv
// Checks an odd-counter stream (each sample = previous + 2) with an
// IDLE/ACQUIRE/LOCKED tracker that tolerates short bursts of bad samples.
module odd_seq_monitor
    import odd_mon_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CNT_W         = 8,
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [WIDTH-1:0]   sample_in,
    input  logic               clear,
    output logic               locked,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   wrap_count,
    output logic [WIDTH-1:0]   last_sample,
    output logic [STATE_W-1:0] state
);

    localparam int GR_W = $clog2(LOCK_THRESH + 1);
    localparam int BR_W = $clog2(UNLOCK_THRESH + 1);
    localparam logic [GR_W-1:0] LOCK_C   = GR_W'(LOCK_THRESH);
    localparam logic [GR_W-1:0] GR_ONE   = GR_W'(1);
    localparam logic [BR_W-1:0] UNLOCK_C = BR_W'(UNLOCK_THRESH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ref_q, ref_d;
    logic [GR_W-1:0]   good_run_q, good_run_d, good_run_inc;
    logic [BR_W-1:0]   bad_run_q, bad_run_d, bad_run_inc;
    logic              err_q, err_d;
    logic              locked_q;
    logic [WIDTH-1:0]  exp_val;
    logic              odd_s;
    logic              good_s;
    logic              wrap_inc;

    assign exp_val      = WIDTH'(next_odd(32'(ref_q)));
    assign odd_s        = sample_in[0];
    assign good_s       = odd_s && (sample_in == exp_val);
    assign good_run_inc = good_run_q + 1'b1;
    assign bad_run_inc  = bad_run_q + 1'b1;

    // Only genuine samples can wrap; flywheel advances never reach this term.
    assign wrap_inc = sample_valid && !clear && good_s &&
                      (ref_q == '1) && (sample_in == WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        err_d      = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            ref_d      = '0;
            good_run_d = '0;
            bad_run_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        if (odd_s) begin
                            ref_d      = sample_in;
                            good_run_d = GR_ONE;
                            state_d    = ACQUIRE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ACQUIRE: begin
                    if (sample_valid) begin
                        if (good_s) begin
                            ref_d      = sample_in;
                            good_run_d = good_run_inc;
                            if (good_run_inc == LOCK_C) begin
                                state_d   = LOCKED;
                                bad_run_d = '0;
                            end
                        end else begin
                            err_d = 1'b1;
                            if (odd_s) begin
                                ref_d      = sample_in;
                                good_run_d = GR_ONE;
                            end else begin
                                good_run_d = '0;
                                state_d    = IDLE;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (sample_valid) begin
                        if (good_s) begin
                            ref_d     = sample_in;
                            bad_run_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (bad_run_inc < UNLOCK_C) begin
                                // Flywheel: coast on the predicted value.
                                bad_run_d = bad_run_inc;
                                ref_d     = exp_val;
                            end else begin
                                bad_run_d  = '0;
                                good_run_d = '0;
                                if (odd_s) begin
                                    ref_d      = sample_in;
                                    good_run_d = GR_ONE;
                                    state_d    = ACQUIRE;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    good_run_d = '0;
                    bad_run_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ref_q      <= '0;
            good_run_q <= '0;
            bad_run_q  <= '0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            err_q      <= err_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (err_d),
        .q     (err_count)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (wrap_inc),
        .q     (wrap_count)
    );

    assign locked      = locked_q;
    assign err_pulse   = err_q;
    assign last_sample = ref_q;
    assign state       = state_q;

endmodule
